// File: rtl/bin2bcd_serial_if.sv
// Request/result bundle for the serial binary-to-BCD converter.
//
// Handshake: the master raises start for one or more clock edges with
// binary_in valid on each of those edges. Every sampled start begins a new
// conversion and discards any conversion in flight. The slave drops done
// from that edge onward. It raises done once bcd_out holds the result for
// the last sampled binary_in. bcd_out and done then stay constant until the
// next start. There is no back-pressure: the converter always accepts start.
interface bin2bcd_serial_if #(
  parameter int BINARY_BITS = 8,
  parameter int BCD_DIGITS  = 4
);
  logic                    start;
  logic [BINARY_BITS-1:0]  binary_in;
  logic [4*BCD_DIGITS-1:0] bcd_out;
  logic                    done;

  modport master (
    output start,
    output binary_in,
    input  bcd_out,
    input  done
  );

  modport slave (
    input  start,
    input  binary_in,
    output bcd_out,
    output done
  );
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (double dabble, one input bit per clock).
// A start edge loads the operand. BINARY_BITS shift edges follow, then one
// completion edge registers the result. bcd_out only changes on completion.
module bin2bcd_serial #(
  parameter int BCD_DIGITS  = 4,
  parameter int BINARY_BITS = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  bin2bcd_serial_if.slave  bus,
  output logic [1:0]       dbg_state
);

  localparam int W  = 4 * BCD_DIGITS;
  localparam int CW = $clog2(BINARY_BITS + 1);

  // True when BCD_DIGITS decimal digits can hold the largest input value.
  function automatic bit cfg_ok();
    longint unsigned p10;
    longint unsigned max_in;
    p10 = 1;
    for (int i = 0; i < BCD_DIGITS; i++) p10 = p10 * 10;
    max_in = (longint'(1) << BINARY_BITS) - 1;
    return p10 > max_in;
  endfunction

  localparam bit CFG_OK = cfg_ok();

  if (!CFG_OK) begin : g_bad_cfg
    $error("bin2bcd_serial: BCD_DIGITS too small for BINARY_BITS");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [BINARY_BITS-1:0] bin_q,   bin_d;
  logic [W-1:0]           acc_q,   acc_d;
  logic [CW-1:0]          cnt_q,   cnt_d;
  logic [W-1:0]           bcd_q,   bcd_d;
  logic                   done_q,  done_d;

  logic [W-1:0]           acc_adj;
  logic [3:0]             dig;

  // Add 3 to every accumulator digit that is 5 or more, before the shift.
  always_comb begin
    acc_adj = acc_q;
    dig     = 4'd0;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      dig = acc_q[4*k +: 4];
      acc_adj[4*k +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
  end

  // Next-state logic. A sampled start always wins, so it restarts a
  // conversion in flight. In DONE, copying the accumulator every cycle is
  // harmless because the accumulator is frozen there.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = done_q;

    if (bus.start) begin
      bin_d   = bus.binary_in;
      acc_d   = '0;
      cnt_d   = CW'(BINARY_BITS);
      done_d  = 1'b0;
      state_d = SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
          {acc_d, bin_d} = {acc_adj, bin_q} << 1;
          cnt_d          = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = DONE;
        end
        DONE: begin
          bcd_d  = acc_q;
          done_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset aborts any conversion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign bus.bcd_out = bcd_q;
  assign bus.done    = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Bench for bin2bcd_serial: directed and random conversions checked against
// a decimal-arithmetic model through an expected-result queue.
module tb_bin2bcd_serial;

  localparam int B = 8;
  localparam int D = 4;
  localparam int W = 4 * D;

  logic       clock;
  logic       reset_n;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_bcd;

  bin2bcd_serial_if #(.BINARY_BITS(B), .BCD_DIGITS(D)) bif ();

  bin2bcd_serial #(.BCD_DIGITS(D), .BINARY_BITS(B)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bif.slave),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Decimal formatting of v into packed BCD digits.
  function automatic logic [W-1:0] bcd_model(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: present one start edge, then wait for completion and check.
  task automatic run_conv(input int v);
    int early;
    int moved;
    logic [W-1:0] exp;
    @(posedge clock); #1;
    bif.start     = 1'b1;
    bif.binary_in = B'(v);
    @(posedge clock); #1;                 // just after start edge E0
    bif.start = 1'b0;
    exp_q.push_back(bcd_model(v));
    check("done_low_after_start", 32'(bif.done), 32'd0);
    early = 0;
    moved = 0;
    for (int i = 1; i <= B; i++) begin    // after E1..E8
      @(posedge clock); #1;
      if (bif.done)              early++;
      if (bif.bcd_out !== last_bcd) moved++;
    end
    check("done_early_cycles", 32'(early), 32'd0);
    check("bcd_held_during_conv", 32'(moved), 32'd0);
    @(posedge clock); #1;                 // after E9
    exp = exp_q.pop_front();
    check("done_at_latency", 32'(bif.done), 32'd1);
    check($sformatf("bcd_of_%0d", v), 32'(bif.bcd_out), 32'(exp));
    last_bcd = exp;
  endtask

  initial begin
    int early;
    int moved;
    logic [W-1:0] exp;

    reset_n       = 1'b0;
    bif.start     = 1'b0;
    bif.binary_in = '0;
    last_bcd      = '0;
    #1;
    check("reset_bcd", 32'(bif.bcd_out), 32'd0);
    check("reset_done", 32'(bif.done), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("idle_bcd", 32'(bif.bcd_out), 32'd0);
    check("idle_done", 32'(bif.done), 32'd0);

    // Sweep 0..110 covers 0..6, 99, 100, 110.
    for (int v = 0; v <= 110; v++) run_conv(v);

    // Maximum value, then hold with binary_in changing but no start.
    run_conv(255);
    repeat (3) @(posedge clock);
    #1 bif.binary_in = 8'd17;
    repeat (3) @(posedge clock);
    #1;
    check("hold_bcd", 32'(bif.bcd_out), 32'h0255);
    check("hold_done", 32'(bif.done), 32'd1);

    // Random values.
    for (int n = 0; n < 40; n++) run_conv(int'($urandom_range(0, 255)));

    // Restart: 42 at E0, 77 sampled three edges later.
    @(posedge clock); #1;
    bif.start = 1'b1; bif.binary_in = 8'd42;
    @(posedge clock); #1;
    bif.start = 1'b0;
    early = 0;
    moved = 0;
    repeat (2) begin
      @(posedge clock); #1;
      if (bif.done) early++;
      if (bif.bcd_out !== last_bcd) moved++;
    end
    bif.start = 1'b1; bif.binary_in = 8'd77;
    @(posedge clock); #1;                 // new start edge
    bif.start = 1'b0;
    exp_q.push_back(bcd_model(77));
    for (int i = 1; i <= B; i++) begin
      @(posedge clock); #1;
      if (bif.done) early++;
      if (bif.bcd_out !== last_bcd) moved++;
    end
    check("restart_no_early_done", 32'(early), 32'd0);
    check("restart_bcd_held", 32'(moved), 32'd0);
    @(posedge clock); #1;
    exp = exp_q.pop_front();
    check("restart_done", 32'(bif.done), 32'd1);
    check("restart_bcd", 32'(bif.bcd_out), 32'(exp));
    last_bcd = exp;

    // start held for three edges: only the last value completes.
    @(posedge clock); #1;
    bif.start = 1'b1; bif.binary_in = 8'd10;
    @(posedge clock); #1 bif.binary_in = 8'd20;
    @(posedge clock); #1 bif.binary_in = 8'd203;
    @(posedge clock); #1;
    bif.start = 1'b0;
    exp_q.push_back(bcd_model(203));
    early = 0;
    for (int i = 1; i <= B; i++) begin
      @(posedge clock); #1;
      if (bif.done) early++;
    end
    check("held_start_no_early_done", 32'(early), 32'd0);
    @(posedge clock); #1;
    exp = exp_q.pop_front();
    check("held_start_done", 32'(bif.done), 32'd1);
    check("held_start_bcd", 32'(bif.bcd_out), 32'(exp));
    last_bcd = exp;

    // Asynchronous reset mid-conversion.
    @(posedge clock); #1;
    bif.start = 1'b1; bif.binary_in = 8'd200;
    @(posedge clock); #1;
    bif.start = 1'b0;
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_bcd", 32'(bif.bcd_out), 32'd0);
    check("async_reset_done", 32'(bif.done), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    last_bcd = '0;
    exp_q.delete();
    repeat (12) @(posedge clock);
    #1;
    check("post_reset_idle_bcd", 32'(bif.bcd_out), 32'd0);
    check("post_reset_idle_done", 32'(bif.done), 32'd0);

    // Converter still works after the abort.
    run_conv(0);
    run_conv(128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin2bcd_serial.md
Name: bin2bcd_serial

Overview:
- Multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock.
- Converts an unsigned BINARY_BITS-wide value into BCD_DIGITS packed BCD digits.
- Used where a display or ASCII formatting path needs decimal digits and latency is not critical.
- Result is registered and held stable until the next conversion completes.

Parameters:
- BCD_DIGITS, 4, number of output BCD digits; bcd_out width = 4*BCD_DIGITS.
- BINARY_BITS, 8, width of the unsigned binary input.
- Legal configurations satisfy 10^BCD_DIGITS > 2^BINARY_BITS - 1.
- An elaboration-time check rejects illegal configurations.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  conversion request, sampled on the rising edge.
- binary_in  in  BINARY_BITS  unsigned value, sampled on the edge where start=1.
- bcd_out  out  4*BCD_DIGITS  packed BCD result; digit k occupies [4k+3:4k], with digit 0 the units digit.
- done  out  1  high when bcd_out holds the result of the most recent conversion.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - bcd_out=0, done=0, FSM=IDLE, working registers cleared.
  - Reset asserted mid-conversion aborts the conversion.
- States: IDLE, SHIFT, DONE.
- IDLE/DONE + start=1 at edge E0:
  - load the binary shift register with binary_in and clear the BCD accumulator (4*BCD_DIGITS bits);
  - load bit counter = BINARY_BITS, go to SHIFT, done<=0.
  - done must therefore be low from E0 onward.
- SHIFT, each edge:
  - every accumulator digit >=5 gets +3 (4-bit add, per digit);
  - then shift {accumulator, binary} left by 1, with the binary MSB entering accumulator bit 0;
  - decrement the counter.
  - After BINARY_BITS iterations (edges E1..E_BINARY_BITS), go to DONE.
- Completion, on the edge after the last shift (E_BINARY_BITS+1):
  - bcd_out <= accumulator, done <= 1.
  - Total latency is BINARY_BITS+1 cycles from the start-sampling edge to done=1 (9 cycles for the defaults).
- DONE: done stays 1 and bcd_out stays constant indefinitely until the next start is sampled.
- bcd_out changes only at completion.
  - During SHIFT, bcd_out keeps the previous result (0 after reset); only done drops.
- start=1 while in SHIFT: abort the current conversion and restart with the newly sampled binary_in.
  - Latency is counted from the new start edge.
- start held high for several cycles: each sampled edge restarts.
  - Only the final start edge's value completes.
- Digit range: every output digit is always 0..9; unused high digits are 0.
- Value 0 converts to all-zero digits, with the same latency as any other value.

Test Plan:
- Reset: assert reset_n=0 mid-operation -> bcd_out=0x0000, done=0 immediately, no clock needed. Release, then idle -> outputs unchanged.
- Basic values (8-bit, 4 digits): binary_in 0..6 -> bcd_out 0x0000..0x0006. Check done is low on the cycle after start and goes high exactly 9 cycles after the start edge.
- Sweep 0..110 with a one-cycle start pulse each:
  - 99 -> 0x0099;
  - 100 -> 0x0100;
  - 110 -> 0x0110;
  - units/tens/hundreds match decimal formatting; thousands digit is 0.
- Max value: 255 -> bcd_out 0x0255, done=1.
- Hold: after done, leave start=0 for 2+ cycles -> bcd_out and done unchanged. Change binary_in without start -> no effect.
- Restart: start with 42, then start with 77 three cycles later -> no done for 42; done 9 cycles after the second start, bcd_out=0x0077. bcd_out keeps its prior value throughout.
